// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a small circular byte FIFO
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;
    localparam logic [15:0] LAST   = 16'(CLKS_PER_BIT - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          done_q, done_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          push, pop, bit_end;

    assign o_TX_Ready   = count_q != CW'(FIFO_DEPTH);
    assign o_TX_Serial  = serial_q;
    assign o_TX_Done    = done_q;
    assign o_TX_Active  = state_q == START || state_q == DATA || state_q == STOP;
    assign o_FIFO_Count = count_q;

    always_comb begin
        push     = i_TX_DV && o_TX_Ready;
        pop      = state_q == IDLE && count_q != '0;
        bit_end  = clk_cnt_q == LAST;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
        state_d   = state_q;
        clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d  = !pop;
                clk_cnt_d = 16'd0;
                bit_idx_d = 3'd0;
                shift_d   = pop ? mem_q[rd_ptr_q] : shift_q;
                state_d   = pop ? START : IDLE;
            end
            START: begin
                serial_d = bit_end ? shift_q[0] : 1'b0;
                state_d  = bit_end ? DATA : START;
            end
            DATA: begin
                if (bit_end) begin
                    serial_d  = bit_idx_q == 3'd7 ? 1'b1 : shift_q[bit_idx_q + 3'd1];
                    state_d   = bit_idx_q == 3'd7 ? STOP : DATA;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                serial_d = 1'b1;
                done_d   = bit_end;
                state_d  = bit_end ? CLEANUP : STOP;
            end
            CLEANUP: begin
                serial_d  = 1'b1;
                clk_cnt_d = 16'd0;
                state_d   = IDLE;
            end
            default: begin
                serial_d  = 1'b1;
                clk_cnt_d = 16'd0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // storage needs no reset: pointers and count define what is valid
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && push) mem_q[wr_ptr_q] <= i_TX_Byte;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of framing, FIFO queuing, full-drop and mid-frame reset
module tb_uart_tx_buffered;
    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done;
    logic [2:0] o_FIFO_Count;
    int n_run = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [7:0] v2 [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    logic [2:0] c2 [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       r2 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] v3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_TX_DV(i_TX_DV), .i_TX_Byte(i_TX_Byte),
        .o_TX_Ready(o_TX_Ready), .o_TX_Serial(o_TX_Serial), .o_TX_Active(o_TX_Active),
        .o_TX_Done(o_TX_Done), .o_FIFO_Count(o_FIFO_Count)
    );

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) if (o_TX_Done === 1'b1) n_done++;

    task automatic tick;
        @(posedge i_Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // index i counts cycles since the start-bit edge; bits are 4 cycles wide
    task automatic check_frame(input logic [7:0] b, input int first);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = first; i < 40; i++) begin
            chk($sformatf("serial %02h c%0d", b, i), o_TX_Serial, fr[i / 4]);
            chk($sformatf("active %02h c%0d", b, i), o_TX_Active, 1);
            chk($sformatf("done %02h c%0d", b, i), o_TX_Done, 0);
            if (i < 39) tick();
        end
        tick();
        chk($sformatf("done pulse %02h", b), o_TX_Done, 1);
        chk($sformatf("active off %02h", b), o_TX_Active, 0);
        chk($sformatf("cleanup line %02h", b), o_TX_Serial, 1);
        tick();
        chk($sformatf("done end %02h", b), o_TX_Done, 0);
        chk($sformatf("idle line %02h", b), o_TX_Serial, 1);
    endtask

    initial begin
        tick();
        tick();
        i_Reset = 1'b0;
        chk("rst serial", o_TX_Serial, 1);
        chk("rst active", o_TX_Active, 0);
        chk("rst done", o_TX_Done, 0);
        chk("rst ready", o_TX_Ready, 1);
        chk("rst count", o_FIFO_Count, 0);

        i_TX_DV = 1'b1;
        i_TX_Byte = 8'h55;
        tick();
        i_TX_DV = 1'b0;
        i_TX_Byte = 8'hEE;
        chk("t1 count", o_FIFO_Count, 1);
        chk("t1 line before pop", o_TX_Serial, 1);
        chk("t1 active before pop", o_TX_Active, 0);
        tick();
        chk("t1 count after pop", o_FIFO_Count, 0);
        check_frame(8'h55, 0);
        chk("t1 done count", n_done, 1);

        for (int k = 0; k < 6; k++) begin
            i_TX_DV = 1'b1;
            i_TX_Byte = v2[k];
            tick();
            chk($sformatf("t2 count w%0d", k), o_FIFO_Count, c2[k]);
            chk($sformatf("t2 ready w%0d", k), o_TX_Ready, r2[k]);
        end
        i_TX_DV = 1'b0;
        check_frame(8'hA5, 4);
        chk("t2 count after A5", o_FIFO_Count, 4);
        for (int k = 1; k < 5; k++) begin
            tick();
            check_frame(v2[k], 0);
        end
        chk("t2 drained", o_FIFO_Count, 0);
        chk("t2 done count", n_done, 6);

        for (int k = 0; k < 5; k++) begin
            i_TX_DV = 1'b1;
            i_TX_Byte = v3[k];
            tick();
        end
        i_TX_Byte = 8'h66;
        chk("t3 full count", o_FIFO_Count, 4);
        chk("t3 full ready", o_TX_Ready, 0);
        check_frame(8'h11, 3);
        chk("t3 count held", o_FIFO_Count, 4);
        chk("t3 ready held", o_TX_Ready, 0);
        tick();
        chk("t3 pop line", o_TX_Serial, 0);
        chk("t3 pop count", o_FIFO_Count, 3);
        chk("t3 pop ready", o_TX_Ready, 1);
        tick();
        i_TX_DV = 1'b0;
        chk("t3 refill count", o_FIFO_Count, 4);
        chk("t3 refill ready", o_TX_Ready, 0);
        check_frame(8'h22, 1);
        tick(); check_frame(8'h33, 0);
        tick(); check_frame(8'h44, 0);
        tick(); check_frame(8'h55, 0);
        tick(); check_frame(8'h66, 0);
        chk("t3 done count", n_done, 12);

        i_TX_DV = 1'b1;
        i_TX_Byte = 8'hC3; tick();
        i_TX_Byte = 8'hA1; tick();
        i_TX_Byte = 8'hB2; tick();
        i_TX_DV = 1'b0;
        repeat (16) tick();
        chk("t4 bit3 low", o_TX_Serial, 0);
        chk("t4 queued", o_FIFO_Count, 2);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("t4 line high", o_TX_Serial, 1);
        chk("t4 count", o_FIFO_Count, 0);
        chk("t4 active", o_TX_Active, 0);
        chk("t4 ready", o_TX_Ready, 1);
        chk("t4 done", o_TX_Done, 0);
        repeat (60) tick();
        chk("t4 no done", n_done, 12);
        chk("t4 idle line", o_TX_Serial, 1);
        i_TX_DV = 1'b1;
        i_TX_Byte = 8'h12;
        tick();
        i_TX_DV = 1'b0;
        tick();
        check_frame(8'h12, 0);
        chk("t4 done count", n_done, 13);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
